// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   CLK_FREQ_DEF / BAUD_DEF : default system clock and line rate
//   bit_cyc()               : system clock cycles per UART bit time
//   cnt_width()             : counter width able to hold 0..n-1 (minimum 1)
//   state_e                 : scheduler FSM states
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEF = 50_000_000;
    localparam int unsigned BAUD_DEF     = 9600;

    function automatic int unsigned bit_cyc(input int unsigned clk_freq,
                                            input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the requester
// after rr_ptr and wraps modulo N; the first valid requester wins.
//   req      : per-requester request
//   rr_ptr   : index of the most recent winner
//   grant    : one-hot winner (all zero when nobody requests)
//   grant_id : binary index of the winner
//   any      : at least one request is present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   rr_ptr,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_id,
    output logic         any
);

    // Both loops are constant-bounded, so every bit select uses a constant
    // index; the rotating priority is expressed by comparing positions.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (((int'(rr_ptr) + k) % N) == i)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = 3'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART transmitter between
// N_REQ requesters.
//   clk, rst     : system clock, asynchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : per-requester byte, slice i is [8*i+7:8*i]
//   req_ready    : one-hot accept towards the requesters
//   tx_start     : one-cycle start pulse to the transmitter
//   tx_data      : byte for the transmitter, held until the next transfer
//   tx_busy      : transmitter is serializing a frame
//   grant_id     : requester owning the current frame
//   active       : scheduler is not idle
//   timeout_err  : pulse when tx_busy never rose after tx_start
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request while the transmitter is free
// START     | tx_start pulse, timeout counter cleared
// WAIT_BUSY | waiting for the transmitter to acknowledge with tx_busy
// WAIT_DONE | frame on the line, waiting for tx_busy to fall
// GAP       | enforced idle time between frames
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
    parameter int unsigned BAUD         = BAUD_DEF,
    parameter int unsigned GAP_BITS     = 1,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [2:0]         grant_id,
    output logic               active,
    output logic               timeout_err
);

    localparam int unsigned BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam int unsigned GAP_CYC = GAP_BITS * BIT_CYC;
    localparam int          GW      = int'(cnt_width(GAP_CYC));
    localparam int          TW      = int'(cnt_width(BUSY_TIMEOUT));

    // GAP is unreachable when GAP_CYC is zero, so its terminal value is moot.
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    state_e          state_q,    state_d;
    logic [2:0]      rr_ptr_q,   rr_ptr_d;
    logic [7:0]      tx_data_q,  tx_data_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [TW-1:0]   tmo_cnt_q,  tmo_cnt_d;
    logic [GW-1:0]   gap_cnt_q,  gap_cnt_d;

    logic [N_REQ-1:0] arb_grant;
    logic [2:0]       arb_id;
    logic             arb_any;
    logic [7:0]       sel_byte;

    rr_arbiter #(
        .N (int'(N_REQ))
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_grant[i]) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                // A foreign user of the transmitter blocks acceptance.
                if (!tx_busy && arb_any) begin
                    req_ready  = arb_grant;
                    tx_data_d  = sel_byte;
                    grant_id_d = arb_id;
                    rr_ptr_d   = arb_id;
                    state_d    = START;
                end
            end
            START: begin
                tx_start  = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 3'(N_REQ - 1);
            tx_data_q  <= 8'h00;
            grant_id_q <= 3'd0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: instance A uses the default gap of one
// bit time (5208 cycles), instance B is built with GAP_BITS=0. Each has a
// small transmitter model that holds tx_busy for BUSY_LEN cycles.
module tb_uart_tx_sched;

    localparam int BUSY_LEN = 40;
    localparam int GAP_EXP  = 5208;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_data, b_data;
    logic        a_start, a_busy, a_active, a_tmo;
    logic        b_start, b_busy, b_active, b_tmo;
    logic [7:0]  a_txd, b_txd;
    logic [2:0]  a_gid, b_gid;
    logic        a_model_en;
    int          a_cnt, b_cnt;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_sched #(.N_REQ(4), .GAP_BITS(1), .BUSY_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .tx_start(a_start), .tx_data(a_txd),
        .tx_busy(a_busy), .grant_id(a_gid), .active(a_active),
        .timeout_err(a_tmo)
    );

    uart_tx_sched #(.N_REQ(4), .GAP_BITS(0), .BUSY_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .tx_start(b_start), .tx_data(b_txd),
        .tx_busy(b_busy), .grant_id(b_gid), .active(b_active),
        .timeout_err(b_tmo)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_busy <= 1'b0;
            a_cnt  <= 0;
        end else if (a_start && a_model_en) begin
            a_busy <= 1'b1;
            a_cnt  <= BUSY_LEN;
        end else if (a_cnt > 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_busy <= 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_busy <= 1'b0;
            b_cnt  <= 0;
        end else if (b_start) begin
            b_busy <= 1'b1;
            b_cnt  <= BUSY_LEN;
        end else if (b_cnt > 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete frame on instance A, including measurement of the gap.
    task automatic frame_a(input logic [3:0] v, input int exp_id,
                           input logic [7:0] exp_b, input bit keep);
        int n;
        a_valid = v;
        #1;
        n = 0;
        while (a_ready == 4'h0 && n < 8000) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(n < 8000), 32'd1);
        chk("ready_not_busy", 32'(a_busy), 32'd0);
        chk("ready_onehot", 32'(a_ready), 32'(1 << exp_id));
        tick();
        if (!keep) a_valid = 4'h0;
        chk("start", 32'(a_start), 32'd1);
        chk("grant_id", 32'(a_gid), 32'(exp_id));
        chk("tx_data", 32'(a_txd), 32'(exp_b));
        tick();
        chk("start_once", 32'(a_start), 32'd0);
        n = 0;
        while (a_busy && n < 200) begin
            tick();
            n++;
        end
        chk("busy_fall", 32'(n < 200), 32'd1);
        chk("ready_in_done", 32'(a_ready), 32'd0);
        tick();
        n = 0;
        while (a_active && n < 6000) begin
            n++;
            tick();
        end
        chk("gap_len", 32'(n), 32'(GAP_EXP));
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        a_valid    = 4'h0;
        b_valid    = 4'h0;
        a_data     = 32'h13121110;
        b_data     = 32'h44332211;
        a_model_en = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_start", 32'(a_start), 32'd0);
        chk("rst_txd", 32'(a_txd), 32'h00);
        chk("rst_gid", 32'(a_gid), 32'd0);
        chk("rst_active", 32'(a_active), 32'd0);
        chk("rst_tmo", 32'(a_tmo), 32'd0);
        chk("rst_b_active", 32'(b_active), 32'd0);
        rst = 1'b0;
        tick();

        // GAP_BITS=0: the next accept comes one cycle after tx_busy falls.
        b_valid = 4'b0011;
        #1;
        chk("b_ready0", 32'(b_ready), 32'b0001);
        tick();
        chk("b_start", 32'(b_start), 32'd1);
        chk("b_gid", 32'(b_gid), 32'd0);
        chk("b_txd", 32'(b_txd), 32'h11);
        tick();
        n = 0;
        while (b_busy && n < 200) begin
            tick();
            n++;
        end
        chk("b_busy_fall", 32'(n < 200), 32'd1);
        chk("b_ready_fallcyc", 32'(b_ready), 32'd0);
        chk("b_active_fallcyc", 32'(b_active), 32'd1);
        tick();
        chk("b_ready_next", 32'(b_ready), 32'b0010);
        chk("b_active_idle", 32'(b_active), 32'd0);
        b_valid = 4'h0;
        tick();

        // Contention: all valid, grants rotate starting from requester 0.
        frame_a(4'hF, 0, 8'h10, 1'b1);
        frame_a(4'hF, 1, 8'h11, 1'b1);
        frame_a(4'hF, 2, 8'h12, 1'b1);
        frame_a(4'hF, 3, 8'h13, 1'b1);
        frame_a(4'hF, 0, 8'h10, 1'b0);

        // Single request from requester 2.
        a_data[23:16] = 8'hA5;
        frame_a(4'b0100, 2, 8'hA5, 1'b0);

        // Pointer wrap: grant 3, then 1 beats 3.
        frame_a(4'b1000, 3, 8'h13, 1'b0);
        frame_a(4'b1010, 1, 8'h11, 1'b0);

        // Timeout: transmitter never acknowledges.
        a_model_en = 1'b0;
        a_valid    = 4'b0001;
        #1;
        chk("tmo_ready", 32'(a_ready), 32'b0001);
        tick();
        a_valid = 4'h0;
        chk("tmo_start", 32'(a_start), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!a_tmo && n < 20);
        chk("tmo_delay", 32'(n), 32'd8);
        chk("tmo_active", 32'(a_active), 32'd1);
        tick();
        chk("tmo_pulse_once", 32'(a_tmo), 32'd0);
        n = 0;
        while (a_active && n < 6000) begin
            n++;
            tick();
        end
        chk("tmo_gap_len", 32'(n), 32'(GAP_EXP));
        a_model_en = 1'b1;

        // Reset during WAIT_DONE.
        a_valid = 4'b0001;
        #1;
        chk("mid_ready", 32'(a_ready), 32'b0001);
        tick();
        a_valid = 4'h0;
        chk("mid_start", 32'(a_start), 32'd1);
        tick();
        tick();
        chk("mid_active", 32'(a_active), 32'd1);
        chk("mid_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_active", 32'(a_active), 32'd0);
        chk("mid_rst_txd", 32'(a_txd), 32'h00);
        chk("mid_rst_gid", 32'(a_gid), 32'd0);
        chk("mid_rst_start", 32'(a_start), 32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        tick();
        chk("mid_rst_start2", 32'(a_start), 32'd0);
        rst     = 1'b0;
        a_valid = 4'hF;
        #1;
        chk("post_rst_ready", 32'(a_ready), 32'b0001);
        tick();
        a_valid = 4'h0;
        chk("post_rst_start", 32'(a_start), 32'd1);
        chk("post_rst_gid", 32'(a_gid), 32'd0);
        chk("post_rst_txd", 32'(a_txd), 32'h10);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
